// File: rtl/bcd_down_timer_pkg.sv
// bcd_down_timer_pkg
//   Constants, state encoding and helpers shared by the BCD down-timer
//   and its per-decade counter.
package bcd_down_timer_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Force any non-decimal nibble down to 9 so Q never shows an illegal code.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit
//   One decimal decade of the down-counter.
//   Ports:
//     CP  - clock, rising edge
//     Rd  - asynchronous active-low reset (q -> 0)
//     ld  - synchronous load of d (wins over en)
//     en  - decrement this edge; 0 wraps to 9
//     d   - value to load (already a valid BCD digit)
//     q   - current digit
//     bz  - digit is zero (borrow-out enable for the next decade)
module bcd_down_digit
  import bcd_down_timer_pkg::*;
(
  input  logic       CP,
  input  logic       Rd,
  input  logic       ld,
  input  logic       en,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       bz
);

  logic [3:0] q_reg;

  always_ff @(posedge CP or negedge Rd) begin
    if (!Rd) begin
      q_reg <= BCD_ZERO;
    end else if (ld) begin
      q_reg <= d;
    end else if (en) begin
      q_reg <= (q_reg == BCD_ZERO) ? BCD_MAX : q_reg - 4'd1;
    end
  end

  assign q  = q_reg;
  assign bz = (q_reg == BCD_ZERO);

endmodule

// File: rtl/bcd_down_timer.sv
// bcd_down_timer
//   Presettable cascaded-BCD down-counter with load, count enables,
//   optional auto-reload and a one-cycle terminal-count pulse.
//   Parameters:
//     DIGITS - number of BCD decades (1..4)
//   Ports:
//     CP   - clock, rising edge
//     Rd   - asynchronous active-low reset
//     LD   - synchronous load, active-low, highest priority after reset
//     EP,ET- count enables, both must be 1 to decrement
//     AR   - auto-reload on terminal count
//     D    - BCD preset, digit 0 in [3:0]
//     Q    - current BCD count
//     TO   - terminal-count pulse (registered, one cycle)
//     BUSY - high while counting (RUN state)
module bcd_down_timer
  import bcd_down_timer_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                CP,
  input  logic                Rd,
  input  logic                LD,
  input  logic                EP,
  input  logic                ET,
  input  logic                AR,
  input  logic [4*DIGITS-1:0] D,
  output logic [4*DIGITS-1:0] Q,
  output logic                TO,
  output logic                BUSY
);

  localparam logic [DIGITS-1:0] DIGIT0_MASK = DIGITS'(1);

  state_t              state_reg;
  logic [4*DIGITS-1:0] reload_reg;
  logic                to_reg;
  logic                busy_reg;

  logic [4*DIGITS-1:0] d_clamped;
  logic [4*DIGITS-1:0] digit_d;
  logic [4*DIGITS-1:0] q_all;
  logic [DIGITS-1:0]   digit_zero;
  logic [DIGITS-1:0]   lower_zero;
  logic                load_now;
  logic                load_zero;
  logic                count_en;
  logic                q_is_one;
  logic                terminal;
  logic                reload_now;
  logic                digit_ld;

  // Clamp each preset digit independently.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_clamp
      assign d_clamped[4*gi +: 4] = bcd_clamp(D[4*gi +: 4]);
    end
  endgenerate

  assign load_now  = !LD;
  assign load_zero = (d_clamped == '0);

  // A load in the same cycle suppresses counting and any terminal pulse.
  assign count_en  = (state_reg == ST_RUN) && EP && ET && !load_now;

  // Q == 1: digit 0 reads 1 and every higher digit is zero.
  assign q_is_one  = (q_all[3:0] == 4'd1) && (&(digit_zero | DIGIT0_MASK));
  assign terminal  = count_en && q_is_one;
  assign reload_now = terminal && AR;

  // Digits are loaded either from D or, on an auto-reload, from the
  // reload register. Without reload, decrementing 1 naturally lands on 0.
  assign digit_ld = load_now || reload_now;
  assign digit_d  = load_now ? d_clamped : reload_reg;

  // Borrow chain: decade k counts only when every lower decade is zero.
  assign lower_zero[0] = 1'b1;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_chain
      assign lower_zero[gi] = lower_zero[gi-1] && digit_zero[gi-1];
    end
  endgenerate

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_down_digit u_digit (
        .CP (CP),
        .Rd (Rd),
        .ld (digit_ld),
        .en (count_en && lower_zero[gi]),
        .d  (digit_d[4*gi +: 4]),
        .q  (q_all[4*gi +: 4]),
        .bz (digit_zero[gi])
      );
    end
  endgenerate

  always_ff @(posedge CP or negedge Rd) begin
    if (!Rd) begin
      state_reg  <= ST_IDLE;
      reload_reg <= '0;
      to_reg     <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      to_reg <= 1'b0;
      if (load_now) begin
        reload_reg <= d_clamped;
        // A zero preset goes straight to DONE without a TO pulse.
        state_reg  <= load_zero ? ST_DONE : ST_RUN;
        busy_reg   <= !load_zero;
      end else begin
        case (state_reg)
          ST_RUN: begin
            if (terminal) begin
              to_reg <= 1'b1;
              if (!AR) begin
                state_reg <= ST_DONE;
                busy_reg  <= 1'b0;
              end
            end
          end
          ST_IDLE, ST_DONE: begin
            state_reg <= state_reg;
          end
          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Q    = q_all;
  assign TO   = to_reg;
  assign BUSY = busy_reg;

endmodule

// File: tb/tb_bcd_down_timer.sv
module tb_bcd_down_timer;

  logic       CP;
  logic       Rd;
  logic       LD;
  logic       EP;
  logic       ET;
  logic       AR;
  logic [7:0] D;
  logic [7:0] Q;
  logic       TO;
  logic       BUSY;

  int tests_run;
  int tests_failed;

  bcd_down_timer #(.DIGITS(2)) dut (
    .CP   (CP),
    .Rd   (Rd),
    .LD   (LD),
    .EP   (EP),
    .ET   (ET),
    .AR   (AR),
    .D    (D),
    .Q    (Q),
    .TO   (TO),
    .BUSY (BUSY)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge CP);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(n / 10);
    ones = 4'(n % 10);
    return {tens, ones};
  endfunction

  task automatic load(input logic [7:0] val);
    D  = val;
    LD = 1'b0;
    step();
    LD = 1'b1;
  endtask

  task automatic test_reset();
    Rd = 1'b0; LD = 1'b1; EP = 1'b1; ET = 1'b1; AR = 1'b0; D = 8'h00;
    #12;
    tests_run++;
    if (Q !== 8'h00 || TO !== 1'b0 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: Q=%h TO=%b BUSY=%b expected Q=00 TO=0 BUSY=0", Q, TO, BUSY);
    end else $display("[TB] reset_state ok");
    @(negedge CP);
    Rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (Q !== 8'h00 || BUSY !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_ignores_enable: Q=%h BUSY=%b expected Q=00 BUSY=0", Q, BUSY);
      end else $display("[TB] idle_ignores_enable cycle %0d ok", i);
    end
  endtask

  task automatic test_countdown();
    EP = 1'b1; ET = 1'b1; AR = 1'b0;
    load(8'h25);
    tests_run++;
    if (Q !== 8'h25 || TO !== 1'b0 || BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL countdown_load: Q=%h TO=%b BUSY=%b expected Q=25 TO=0 BUSY=1", Q, TO, BUSY);
    end else $display("[TB] countdown_load Q=25 ok");
    for (int n = 24; n >= 0; n--) begin
      step();
      tests_run++;
      if (Q !== to_bcd(n) || TO !== (n == 0) || BUSY !== (n != 0)) begin
        tests_failed++;
        $display("FAIL countdown: Q=%h TO=%b BUSY=%b expected Q=%h TO=%b BUSY=%b",
                 Q, TO, BUSY, to_bcd(n), (n == 0), (n != 0));
      end else $display("[TB] countdown Q=%h TO=%b ok", Q, TO);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (Q !== 8'h00 || TO !== 1'b0 || BUSY !== 1'b0) begin
        tests_failed++;
        $display("FAIL done_hold: Q=%h TO=%b BUSY=%b expected Q=00 TO=0 BUSY=0", Q, TO, BUSY);
      end else $display("[TB] done_hold cycle %0d ok", i);
    end
  endtask

  task automatic test_borrow();
    EP = 1'b1; ET = 1'b1; AR = 1'b0;
    load(8'h10);
    step();
    tests_run++;
    if (Q !== 8'h09 || TO !== 1'b0) begin
      tests_failed++;
      $display("FAIL decade_borrow: Q=%h TO=%b expected Q=09 TO=0", Q, TO);
    end else $display("[TB] decade_borrow Q=09 ok");
  endtask

  task automatic test_autoreload();
    logic [7:0] exp_q [6];
    logic       exp_to [6];
    exp_q  = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03};
    exp_to = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    EP = 1'b1; ET = 1'b1; AR = 1'b1;
    load(8'h03);
    tests_run++;
    if (Q !== 8'h03 || TO !== 1'b0) begin
      tests_failed++;
      $display("FAIL autoreload_load: Q=%h TO=%b expected Q=03 TO=0", Q, TO);
    end else $display("[TB] autoreload_load Q=03 ok");
    for (int i = 0; i < 6; i++) begin
      step();
      tests_run++;
      if (Q !== exp_q[i] || TO !== exp_to[i] || BUSY !== 1'b1) begin
        tests_failed++;
        $display("FAIL autoreload: Q=%h TO=%b BUSY=%b expected Q=%h TO=%b BUSY=1",
                 Q, TO, BUSY, exp_q[i], exp_to[i]);
      end else $display("[TB] autoreload Q=%h TO=%b ok", Q, TO);
    end
    AR = 1'b0;
  endtask

  task automatic test_enable_gating();
    logic [7:0] exp_q [3];
    logic       ep_pat [3];
    exp_q  = '{8'h04, 8'h04, 8'h03};
    ep_pat = '{1'b1, 1'b0, 1'b1};
    ET = 1'b1; AR = 1'b0;
    load(8'h05);
    for (int i = 0; i < 3; i++) begin
      EP = ep_pat[i];
      step();
      tests_run++;
      if (Q !== exp_q[i] || TO !== 1'b0) begin
        tests_failed++;
        $display("FAIL ep_gating: Q=%h TO=%b expected Q=%h TO=0", Q, TO, exp_q[i]);
      end else $display("[TB] ep_gating EP=%b Q=%h ok", ep_pat[i], Q);
    end
    EP = 1'b1; ET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (Q !== 8'h03 || TO !== 1'b0 || BUSY !== 1'b1) begin
        tests_failed++;
        $display("FAIL et_hold: Q=%h TO=%b BUSY=%b expected Q=03 TO=0 BUSY=1", Q, TO, BUSY);
      end else $display("[TB] et_hold cycle %0d ok", i);
    end
    ET = 1'b1;
  endtask

  task automatic test_clamp_priority();
    EP = 1'b1; ET = 1'b1; AR = 1'b0;
    // Counter is running and enabled; the load must win.
    load(8'h3C);
    tests_run++;
    if (Q !== 8'h39 || TO !== 1'b0) begin
      tests_failed++;
      $display("FAIL clamp_low: Q=%h TO=%b expected Q=39 TO=0", Q, TO);
    end else $display("[TB] clamp_low Q=39 ok");
    step();
    tests_run++;
    if (Q !== 8'h38) begin
      tests_failed++;
      $display("FAIL after_clamp_count: Q=%h expected 38", Q);
    end else $display("[TB] after_clamp_count Q=38 ok");
    load(8'hAF);
    tests_run++;
    if (Q !== 8'h99) begin
      tests_failed++;
      $display("FAIL clamp_both: Q=%h expected 99", Q);
    end else $display("[TB] clamp_both Q=99 ok");
    // Load coinciding with a would-be terminal edge: no TO.
    load(8'h02);
    step();
    load(8'h07);
    tests_run++;
    if (Q !== 8'h07 || TO !== 1'b0 || BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_beats_terminal: Q=%h TO=%b BUSY=%b expected Q=07 TO=0 BUSY=1", Q, TO, BUSY);
    end else $display("[TB] load_beats_terminal ok");
    load(8'h00);
    tests_run++;
    if (Q !== 8'h00 || TO !== 1'b0 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_load: Q=%h TO=%b BUSY=%b expected Q=00 TO=0 BUSY=0", Q, TO, BUSY);
    end else $display("[TB] zero_load ok");
    step();
    tests_run++;
    if (Q !== 8'h00 || TO !== 1'b0 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_load_done: Q=%h TO=%b BUSY=%b expected Q=00 TO=0 BUSY=0", Q, TO, BUSY);
    end else $display("[TB] zero_load_done ok");
  endtask

  task automatic test_reset_midrun();
    EP = 1'b1; ET = 1'b1; AR = 1'b0;
    load(8'h40);
    for (int i = 0; i < 5; i++) step();
    tests_run++;
    if (Q !== 8'h35 || BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_count: Q=%h BUSY=%b expected Q=35 BUSY=1", Q, BUSY);
    end else $display("[TB] pre_reset_count Q=35 ok");
    #2;
    Rd = 1'b0;
    #1;
    tests_run++;
    if (Q !== 8'h00 || TO !== 1'b0 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: Q=%h TO=%b BUSY=%b expected Q=00 TO=0 BUSY=0", Q, TO, BUSY);
    end else $display("[TB] async_reset ok");
    #2;
    Rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (Q !== 8'h00 || BUSY !== 1'b0) begin
        tests_failed++;
        $display("FAIL post_reset_idle: Q=%h BUSY=%b expected Q=00 BUSY=0", Q, BUSY);
      end else $display("[TB] post_reset_idle cycle %0d ok", i);
    end
    load(8'h02);
    tests_run++;
    if (Q !== 8'h02 || BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_load: Q=%h BUSY=%b expected Q=02 BUSY=1", Q, BUSY);
    end else $display("[TB] post_reset_load ok");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_countdown();
    test_borrow();
    test_autoreload();
    test_enable_gating();
    test_clamp_priority();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_down_timer.md
# bcd_down_timer

Presettable, cascaded-BCD down-counter with load, count-enable and terminal-count pulse. It is the count-down counterpart of the team's 74160-style decade up-counter. It is used wherever the design needs a decimal countdown, such as countdown displays, phase timers and delays, with `Q` driving the BCD-to-7-segment path directly. Counting stops at zero, or reloads automatically when `AR` is set. Each decimal digit is a separate down-counting decade, and a borrow ripples from each decade to the next higher one.

## Interface
- `DIGITS`, 2, number of BCD decades (1–4).
- `CP` input 1: clock. All state changes occur on its rising edge.
- `Rd` input 1: reset, asynchronous, active-low.
- `LD` input 1: synchronous load, active-low. Takes priority over counting.
- `EP` input 1: count enable.
- `ET` input 1: count enable. The counter decrements only when `EP` and `ET` are both 1.
- `AR` input 1: auto-reload enable. It is sampled at the terminal-count edge.
- `D` input 4*DIGITS: BCD preset value. Digit 0 occupies bits [3:0].
- `Q` output 4*DIGITS: current BCD count.
- `TO` output 1: terminal-count pulse, registered, one cycle long.
- `BUSY` output 1: high while the state is RUN.

## Operation
- State machine has three states: IDLE, RUN and DONE.
- Reset (`Rd`=0), at any time including mid-count:
  - `Q`=0, reload register=0, `TO`=0, state=IDLE.
  - `BUSY`=0.
- Load (`LD`=0), in any state:
  - `D` is written into both `Q` and the reload register.
  - Any digit greater than 9 is clamped to 9.
  - Next state is RUN if the clamped value is non-zero. Otherwise the next state is DONE, and `TO` stays 0.
- IDLE holds `Q`. Enables are ignored; only a load leaves this state.
- RUN with `EP`&`ET`=1 decrements `Q` by one in BCD:
  - Digit 0 decrements every enabled cycle.
  - Digit k decrements only when all lower digits are 0. Those lower digits wrap to 9.
- RUN with `EP`&`ET`=0 holds `Q` and `TO`=0.
- Terminal-count edge occurs in RUN when enabled and `Q`==1:
  - `TO`=1 for the following cycle.
  - If `AR`=1, `Q` takes the reload register value and the state stays RUN.
  - If `AR`=0, `Q`=0 and the state goes to DONE.
- DONE holds `Q`=0 and ignores enables. A load restarts the counter.
- If `LD`=0 and the counter is enabled in the same cycle, the load wins. The decrement is discarded and no `TO` is produced.
- `Q` is always a valid BCD value. No encoding above 9 ever reaches the output.

## Timing
- `Q`, `TO` and `BUSY` are all registered. They update on the `CP` rising edge after the inputs are sampled.
- Load latency is 1 cycle: `Q`=`D` in the cycle after `LD` is sampled low.
- Decrement latency is 1 cycle per enabled edge.
- `TO` is high in exactly the cycle in which `Q` first shows 0 or the reloaded value.
- With `AR`=1 and reload value N, `TO` has a period of N enabled cycles.
- Reset is asynchronous. The outputs clear without waiting for `CP`.
- Reset release is synchronous in effect: the first active edge after `Rd` rises is a normal edge.

## Structure
- Shared package contents:
  - BCD constants `BCD_MAX`=4'd9 and `BCD_ZERO`.
  - A state enum with IDLE, RUN and DONE.
  - A clamp function for digits above 9.
- Sub-module `bcd_down_digit` handles one decade. Its ports are:
  - `CP`, `Rd`, `ld`, `en`, `d[3:0]`, `q[3:0]`, and `bz`, which signals "at zero".
- `bcd_down_digit` behaviour:
  - The digit decrements when `en` is high and wraps 0→9.
  - `en` of digit k = top-level count enable AND `bz` of every lower digit.
- The top level instantiates `DIGITS` copies of `bcd_down_digit` using generate. It also contains:
  - the FSM,
  - the reload register,
  - the `==1` detect,
  - the `TO` register.

## Test plan
- Load 0x25 with `EP`=`ET`=1 and `AR`=0:
  - `Q` runs 0x25, 0x24 … 0x20, 0x19 … 0x01, 0x00.
  - `TO`=1 only in the 0x00 cycle.
  - Then DONE and `BUSY`=0, with `Q` holding 0x00 for 5 more cycles.
- Decade borrow: load 0x10, then one enabled edge gives `Q`=0x09. No `TO` is produced.
- Auto-reload: load 0x03 with `AR`=1.
  - `Q` runs 03, 02, 01, 03, 02, 01, 03.
  - `TO` pulses in each cycle where `Q` returns to 03, i.e. every 3 cycles.
- Enable gating:
  - Toggle `EP` in the pattern 1, 0, 1 while `ET`=1, with load 0x05: `Q` runs 05, 04, 04, 03.
  - With `ET`=0 and `EP`=1, `Q` holds.
- Load clamp and priority:
  - `D`=0x3C with `LD`=0 and the counter enabled gives `Q`=0x39, with no decrement.
  - `D`=0x00 gives DONE with `TO`=0.
- Reset mid-run:
  - Load 0x40, count 5 edges, then pulse `Rd` low between edges.
  - `Q`=0x00, `TO`=0 and `BUSY`=0 immediately, before the next edge.
  - The counter stays in IDLE after release until the next load.
